// File: rtl/rr_arbiter_fourbyone_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
// Holds FSM encodings, sizes and the rotating-priority winner search.
package rr_arbiter_fourbyone_pkg;

   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 2;

   localparam logic IDLE = 1'b0;
   localparam logic BUSY = 1'b1;

   typedef struct packed {
      logic             found;
      logic [SEL_W-1:0] idx;
   } rr_win_t;

   // First set bit of ereq scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
   function automatic rr_win_t rr_pick(
      input logic [NUM_REQ-1:0] ereq,
      input logic [SEL_W-1:0]   ptr
   );
      rr_win_t          res;
      logic [SEL_W-1:0] cand;
      res = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = ptr + SEL_W'(i);
         if (!res.found && ereq[cand]) begin
            res.found = 1'b1;
            res.idx   = cand;
         end
      end
      return res;
   endfunction

   function automatic logic [NUM_REQ-1:0] onehot(
      input logic [SEL_W-1:0] idx
   );
      return NUM_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/rr_arbiter_fourbyone_mux.sv
// Four-to-one word multiplexer, purely combinational.
// Ports: A..D data words, S select (0=A..3=D), Y selected word.
module fourbyone_multiplexer #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] C,
   input  logic [WIDTH-1:0] D,
   input  logic [1:0]       S,
   output logic [WIDTH-1:0] Y
);

   always_comb begin
      Y = A;
      unique case (S)
         2'd0: Y = A;
         2'd1: Y = B;
         2'd2: Y = C;
         2'd3: Y = D;
         default: Y = A;
      endcase
   end

endmodule

// File: rtl/rr_arbiter_fourbyone.sv
// Round-robin arbiter sharing one registered word channel among four
// requesters. Ports: clk, rst (sync, high), REQ, A..D, READY in;
// GNT (one-cycle grant pulse), S (source index), Y (word), VALID out.
module rr_arbiter_fourbyone
   import rr_arbiter_fourbyone_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] REQ,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   input  logic [WIDTH-1:0]   C,
   input  logic [WIDTH-1:0]   D,
   input  logic               READY,
   output logic [NUM_REQ-1:0] GNT,
   output logic [SEL_W-1:0]   S,
   output logic [WIDTH-1:0]   Y,
   output logic               VALID
);

   logic               state;
   logic [SEL_W-1:0]   ptr;
   logic [NUM_REQ-1:0] ereq;
   rr_win_t            win;
   logic [WIDTH-1:0]   mux_y;
   logic               slot_free;
   logic               capture;

   // A requester being acknowledged this cycle still has REQ high;
   // masking it with GNT avoids granting it twice.
   assign ereq      = REQ & ~GNT;
   assign win       = rr_pick(ereq, ptr);
   assign slot_free = (state == IDLE) || READY;
   assign capture   = slot_free && win.found;

   fourbyone_multiplexer #(
      .WIDTH (WIDTH)
   ) u_mux (
      .A (A),
      .B (B),
      .C (C),
      .D (D),
      .S (win.idx),
      .Y (mux_y)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         VALID <= 1'b0;
         GNT   <= '0;
         S     <= '0;
         Y     <= '0;
         ptr   <= '0;
      end else begin
         GNT <= '0;
         if (capture) begin
            Y     <= mux_y;
            S     <= win.idx;
            GNT   <= onehot(win.idx);
            VALID <= 1'b1;
            ptr   <= win.idx + 2'd1;
            state <= BUSY;
         end else if (state == BUSY && READY) begin
            VALID <= 1'b0;
            state <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_rr_arbiter_fourbyone.sv
// Directed bench for rr_arbiter_fourbyone.
// Hand-computed expectations for reset, rotation, stall, wrap.
module tb_rr_arbiter_fourbyone;

   logic       clk;
   logic       rst;
   logic [3:0] REQ;
   logic [7:0] A, B, C, D;
   logic       READY;
   logic [3:0] GNT;
   logic [1:0] S;
   logic [7:0] Y;
   logic       VALID;

   int checks;
   int errors;

   rr_arbiter_fourbyone #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .REQ   (REQ),
      .A     (A),
      .B     (B),
      .C     (C),
      .D     (D),
      .READY (READY),
      .GNT   (GNT),
      .S     (S),
      .Y     (Y),
      .VALID (VALID)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag,
                             input logic [3:0] g,
                             input logic [1:0] s,
                             input logic [7:0] y,
                             input logic v);
      chk({tag, ".gnt"}, 32'(GNT), 32'(g));
      chk({tag, ".s"}, 32'(S), 32'(s));
      chk({tag, ".y"}, 32'(Y), 32'(y));
      chk({tag, ".valid"}, 32'(VALID), 32'(v));
   endtask

   initial begin
      checks = 0;
      errors = 0;
      A = 8'hAA; B = 8'h55; C = 8'hF0; D = 8'h0F;
      REQ = 4'b1111; READY = 1'b1; rst = 1'b1;

      // 1. reset held with all requests pending
      step();
      expect_out("rst0", 4'b0000, 2'd0, 8'h00, 1'b0);
      step();
      expect_out("rst1", 4'b0000, 2'd0, 8'h00, 1'b0);
      rst = 1'b0;
      step();
      expect_out("rst_first", 4'b0001, 2'd0, 8'hAA, 1'b1);
      REQ = 4'b0000;
      step();
      expect_out("rst_drain", 4'b0000, 2'd0, 8'hAA, 1'b0);

      // 2. single request from B
      REQ = 4'b0010;
      step();
      expect_out("single", 4'b0010, 2'd1, 8'h55, 1'b1);
      REQ = 4'b0000;
      step();
      expect_out("single_drain", 4'b0000, 2'd1, 8'h55, 1'b0);

      // 3. full rotation from a fresh pointer
      rst = 1'b1;
      step();
      rst = 1'b0;
      REQ = 4'b1111;
      step();
      expect_out("rot0", 4'b0001, 2'd0, 8'hAA, 1'b1);
      step();
      expect_out("rot1", 4'b0010, 2'd1, 8'h55, 1'b1);
      step();
      expect_out("rot2", 4'b0100, 2'd2, 8'hF0, 1'b1);
      step();
      expect_out("rot3", 4'b1000, 2'd3, 8'h0F, 1'b1);
      step();
      expect_out("rot4", 4'b0001, 2'd0, 8'hAA, 1'b1);

      // 4. backpressure after a grant to C
      step();
      expect_out("pre_b", 4'b0010, 2'd1, 8'h55, 1'b1);
      step();
      expect_out("grant_c", 4'b0100, 2'd2, 8'hF0, 1'b1);
      READY = 1'b0;
      REQ = 4'b1011;
      C = 8'h33;
      for (int i = 0; i < 3; i++) begin
         step();
         expect_out("stall", 4'b0000, 2'd2, 8'hF0, 1'b1);
      end
      C = 8'hF0;
      READY = 1'b1;
      step();
      expect_out("after_stall", 4'b1000, 2'd3, 8'h0F, 1'b1);

      // 5. pointer wrap: A ahead of D
      REQ = 4'b1001;
      step();
      expect_out("wrap_a", 4'b0001, 2'd0, 8'hAA, 1'b1);
      step();
      expect_out("wrap_d", 4'b1000, 2'd3, 8'h0F, 1'b1);

      // 6. reset while a word is stalled
      REQ = 4'b0010;
      step();
      expect_out("mid_b", 4'b0010, 2'd1, 8'h55, 1'b1);
      READY = 1'b0;
      REQ = 4'b1010;
      step();
      expect_out("mid_hold", 4'b0000, 2'd1, 8'h55, 1'b1);
      rst = 1'b1;
      step();
      expect_out("mid_rst", 4'b0000, 2'd0, 8'h00, 1'b0);
      rst = 1'b0;
      READY = 1'b1;
      step();
      expect_out("post_rst", 4'b0010, 2'd1, 8'h55, 1'b1);
      step();
      expect_out("post_rst_d", 4'b1000, 2'd3, 8'h0F, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
